// File: rtl/avg_unpool_single_pkg.sv
// Shared types and constants for the average-pool gradient writer.
package avg_unpool_single_pkg;

    localparam int DATAWIDTH_DEFAULT = 32;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCALE = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/avg_unpool_single_if.sv
// Request and element-write bus of the average-pool gradient writer.
interface avg_unpool_single_if #(
    parameter int DATAWIDTH     = 32,
    parameter int MAT_DIMENSION = 13
);
    localparam int INDEX_WIDTH = $clog2(MAT_DIMENSION) + 1;

    logic                   start;
    logic [DATAWIDTH-1:0]   grad_in;
    logic                   wr_en;
    logic [INDEX_WIDTH-1:0] wr_row;
    logic [INDEX_WIDTH-1:0] wr_col;
    logic [DATAWIDTH-1:0]   wr_data;
    logic [DATAWIDTH-1:0]   mat_out_y [MAT_DIMENSION][MAT_DIMENSION];
    logic                   busy;
    logic                   finished;

    modport master (
        output start, grad_in,
        input  wr_en, wr_row, wr_col, wr_data, mat_out_y, busy, finished
    );

    modport slave (
        input  start, grad_in,
        output wr_en, wr_row, wr_col, wr_data, mat_out_y, busy, finished
    );

endinterface

// File: rtl/mul_fp.sv
// Combinational FP32 multiplier: round-to-nearest-even, subnormals flushed to zero,
// NaN operands returned unchanged, Inf*0 gives the canonical quiet NaN.
module mul_fp (
    input  logic [31:0] flp_a,
    input  logic [31:0] flp_b,
    output logic [31:0] flp_res
);

    logic        sign;
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0] prod;
    logic [22:0] mant;
    logic        guard, sticky, rnd;
    logic [23:0] mant_rnd;
    logic [9:0]  e_fin;
    logic [9:0]  e_res;

    // Unpack, multiply significands, normalise, round and repack.
    always_comb begin
        sign   = flp_a[31] ^ flp_b[31];
        ea     = flp_a[30:23];
        eb     = flp_b[30:23];
        ma     = flp_a[22:0];
        mb     = flp_b[22:0];
        a_nan  = (ea == 8'hFF) && (ma != 23'd0);
        b_nan  = (eb == 8'hFF) && (mb != 23'd0);
        a_inf  = (ea == 8'hFF) && (ma == 23'd0);
        b_inf  = (eb == 8'hFF) && (mb == 23'd0);
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);

        prod = {24'd0, 1'b1, ma} * {24'd0, 1'b1, mb};

        if (prod[47]) begin
            mant   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
        end else begin
            mant   = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
        end

        rnd      = guard & (sticky | mant[0]);
        mant_rnd = {1'b0, mant} + {23'd0, rnd};
        // Biased exponent sum; 127 is subtracted only after the range checks.
        e_fin    = {2'b00, ea} + {2'b00, eb} + {9'd0, prod[47]} + {9'd0, mant_rnd[23]};
        e_res    = e_fin - 10'd127;

        if (a_nan) begin
            flp_res = flp_a;
        end else if (b_nan) begin
            flp_res = flp_b;
        end else if (a_inf || b_inf) begin
            flp_res = (a_zero || b_zero) ? 32'h7FC0_0000 : {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            flp_res = {sign, 31'd0};
        end else if (e_fin <= 10'd127) begin
            flp_res = {sign, 31'd0};
        end else if (e_fin >= 10'd382) begin
            flp_res = {sign, 8'hFF, 23'd0};
        end else begin
            flp_res = {sign, e_res[7:0], mant_rnd[22:0]};
        end
    end

endmodule

// File: rtl/avg_unpool_single.sv
// Average-pool backward path: scales one FP32 gradient by 1/(D*D) and writes it
// to every element of a D x D matrix, row-major, one element per cycle.
module avg_unpool_single
    import avg_unpool_single_pkg::*;
#(
    parameter int                   DATAWIDTH     = DATAWIDTH_DEFAULT,
    parameter int                   MAT_DIMENSION = 13,
    parameter logic [DATAWIDTH-1:0] DIVISOR       = 32'h3bc1e4bc
) (
    input  logic                 clk,
    input  logic                 rst,
    avg_unpool_single_if.slave   bus
);

    localparam int INDEX_WIDTH = $clog2(MAT_DIMENSION) + 1;
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(MAT_DIMENSION - 1);

    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] row_q, row_d;
    logic [INDEX_WIDTH-1:0] col_q, col_d;
    logic [INDEX_WIDTH-1:0] last_row_q, last_row_d;
    logic [INDEX_WIDTH-1:0] last_col_q, last_col_d;
    logic [DATAWIDTH-1:0]   grad_q, grad_d;
    logic [DATAWIDTH-1:0]   scaled_q, scaled_d;
    logic                   finished_q, finished_d;
    logic [DATAWIDTH-1:0]   mat_q [MAT_DIMENSION][MAT_DIMENSION];
    logic [DATAWIDTH-1:0]   mul_res;

    mul_fp u_mul (
        .flp_a   (DIVISOR),
        .flp_b   (grad_q),
        .flp_res (mul_res)
    );

    // State, counters and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            last_row_q <= '0;
            last_col_q <= '0;
            grad_q     <= FP_ZERO;
            scaled_q   <= FP_ZERO;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            last_row_q <= last_row_d;
            last_col_q <= last_col_d;
            grad_q     <= grad_d;
            scaled_q   <= scaled_d;
            finished_q <= finished_d;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        last_row_d = last_row_q;
        last_col_d = last_col_q;
        grad_d     = grad_q;
        scaled_d   = scaled_q;
        finished_d = finished_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    grad_d  = bus.grad_in;
                    state_d = SCALE;
                end
            end
            SCALE: begin
                scaled_d = mul_res;
                row_d    = '0;
                col_d    = '0;
                state_d  = WRITE;
            end
            WRITE: begin
                last_row_d = row_q;
                last_col_d = col_q;
                if (col_q == LAST_IDX) begin
                    col_d = '0;
                    if (row_q == LAST_IDX) begin
                        row_d      = '0;
                        finished_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.start) begin
                    finished_d = 1'b0;
                    grad_d     = bus.grad_in;
                    state_d    = SCALE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gradient matrix: one element captured per WRITE cycle, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < MAT_DIMENSION; r++) begin
                for (int unsigned c = 0; c < MAT_DIMENSION; c++) begin
                    mat_q[r][c] <= FP_ZERO;
                end
            end
        end else if (state_q == WRITE) begin
            for (int unsigned r = 0; r < MAT_DIMENSION; r++) begin
                for (int unsigned c = 0; c < MAT_DIMENSION; c++) begin
                    if (row_q == r[INDEX_WIDTH-1:0] && col_q == c[INDEX_WIDTH-1:0]) begin
                        mat_q[r][c] <= scaled_q;
                    end
                end
            end
        end
    end

    // The counters return to 0 at the end of a run, so the bus shows the shadow
    // copy of the last written coordinate whenever no write is in progress.
    always_comb begin
        bus.wr_en    = (state_q == WRITE);
        bus.busy     = (state_q == SCALE) || (state_q == WRITE);
        bus.finished = finished_q;
        bus.wr_data  = scaled_q;
        bus.wr_row   = (state_q == WRITE) ? row_q : last_row_q;
        bus.wr_col   = (state_q == WRITE) ? col_q : last_col_q;
    end

    assign bus.mat_out_y = mat_q;

endmodule

// File: tb/tb_avg_unpool_single.sv
// Directed bench for avg_unpool_single: a D=2 / 0.25 instance and a default D=13 instance.
module tb_avg_unpool_single;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    avg_unpool_single_if #(.DATAWIDTH(32), .MAT_DIMENSION(2))  bus2  ();
    avg_unpool_single_if #(.DATAWIDTH(32), .MAT_DIMENSION(13)) bus13 ();

    avg_unpool_single #(
        .DATAWIDTH     (32),
        .MAT_DIMENSION (2),
        .DIVISOR       (32'h3E80_0000)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    avg_unpool_single #(
        .DATAWIDTH     (32),
        .MAT_DIMENSION (13),
        .DIVISOR       (32'h3bc1e4bc)
    ) dut13 (
        .clk (clk),
        .rst (rst),
        .bus (bus13)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (bus2.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", bus2.wr_en); end
        n_tests++; if (bus2.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus2.busy); end
        n_tests++; if (bus2.finished !== 1'b0) begin n_fail++; $display("FAIL reset_finished: got %b expected 0", bus2.finished); end
        n_tests++; if (bus2.wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_wr_data: got %h expected 00000000", bus2.wr_data); end
        n_tests++; if (bus2.wr_row !== 2'd0) begin n_fail++; $display("FAIL reset_wr_row: got %0d expected 0", bus2.wr_row); end
        n_tests++; if (bus2.wr_col !== 2'd0) begin n_fail++; $display("FAIL reset_wr_col: got %0d expected 0", bus2.wr_col); end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                n_tests++;
                if (bus2.mat_out_y[r][c] !== 32'h0) begin
                    n_fail++; $display("FAIL reset_mat[%0d][%0d]: got %h expected 00000000", r, c, bus2.mat_out_y[r][c]);
                end
            end
        end
        n_tests++; if (bus13.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy13: got %b expected 0", bus13.busy); end
        n_tests++; if (bus13.mat_out_y[12][12] !== 32'h0) begin n_fail++; $display("FAIL reset_mat13: got %h expected 00000000", bus13.mat_out_y[12][12]); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bus2.grad_in = 32'h4080_0000;
        bus2.start   = 1'b1;
        tick();
        bus2.start = 1'b0;
        n_tests++; if (bus2.busy !== 1'b1) begin n_fail++; $display("FAIL basic_scale_busy: got %b expected 1", bus2.busy); end
        n_tests++; if (bus2.wr_en !== 1'b0) begin n_fail++; $display("FAIL basic_scale_wr_en: got %b expected 0", bus2.wr_en); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++; if (bus2.wr_en !== 1'b1) begin n_fail++; $display("FAIL basic_wr_en%0d: got %b expected 1", k, bus2.wr_en); end
            n_tests++; if (bus2.wr_row !== 2'(k / 2)) begin n_fail++; $display("FAIL basic_row%0d: got %0d expected %0d", k, bus2.wr_row, k / 2); end
            n_tests++; if (bus2.wr_col !== 2'(k % 2)) begin n_fail++; $display("FAIL basic_col%0d: got %0d expected %0d", k, bus2.wr_col, k % 2); end
            n_tests++; if (bus2.wr_data !== 32'h3F80_0000) begin n_fail++; $display("FAIL basic_data%0d: got %h expected 3f800000", k, bus2.wr_data); end
        end
        tick();
        n_tests++; if (bus2.finished !== 1'b1) begin n_fail++; $display("FAIL basic_finished: got %b expected 1", bus2.finished); end
        n_tests++; if (bus2.wr_en !== 1'b0) begin n_fail++; $display("FAIL basic_done_wr_en: got %b expected 0", bus2.wr_en); end
        n_tests++; if (bus2.busy !== 1'b0) begin n_fail++; $display("FAIL basic_done_busy: got %b expected 0", bus2.busy); end
        n_tests++; if (bus2.wr_row !== 2'd1 || bus2.wr_col !== 2'd1) begin n_fail++; $display("FAIL basic_hold_rc: got %0d,%0d expected 1,1", bus2.wr_row, bus2.wr_col); end
        n_tests++; if (bus2.wr_data !== 32'h3F80_0000) begin n_fail++; $display("FAIL basic_hold_data: got %h expected 3f800000", bus2.wr_data); end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                n_tests++;
                if (bus2.mat_out_y[r][c] !== 32'h3F80_0000) begin
                    n_fail++; $display("FAIL basic_mat[%0d][%0d]: got %h expected 3f800000", r, c, bus2.mat_out_y[r][c]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bus2.grad_in = 32'hC100_0000;
        bus2.start   = 1'b1;
        tick();
        bus2.start = 1'b0;
        n_tests++; if (bus2.finished !== 1'b0) begin n_fail++; $display("FAIL b2b_finished_drop: got %b expected 0", bus2.finished); end
        n_tests++; if (bus2.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b expected 1", bus2.busy); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++; if (bus2.wr_en !== 1'b1) begin n_fail++; $display("FAIL b2b_wr_en%0d: got %b expected 1", k, bus2.wr_en); end
            n_tests++; if (bus2.wr_row !== 2'(k / 2) || bus2.wr_col !== 2'(k % 2)) begin n_fail++; $display("FAIL b2b_rc%0d: got %0d,%0d expected %0d,%0d", k, bus2.wr_row, bus2.wr_col, k / 2, k % 2); end
            n_tests++; if (bus2.wr_data !== 32'hC000_0000) begin n_fail++; $display("FAIL b2b_data%0d: got %h expected c0000000", k, bus2.wr_data); end
        end
        tick();
        n_tests++; if (bus2.finished !== 1'b1) begin n_fail++; $display("FAIL b2b_finished: got %b expected 1", bus2.finished); end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                n_tests++;
                if (bus2.mat_out_y[r][c] !== 32'hC000_0000) begin
                    n_fail++; $display("FAIL b2b_mat[%0d][%0d]: got %h expected c0000000", r, c, bus2.mat_out_y[r][c]);
                end
            end
        end
    endtask

    task automatic test_ignored_start();
        bus2.grad_in = 32'h4080_0000;
        bus2.start   = 1'b1;
        tick();
        bus2.start = 1'b0;
        tick();
        tick();
        bus2.start   = 1'b1;
        bus2.grad_in = 32'hC000_0000;
        tick();
        bus2.start = 1'b0;
        n_tests++; if (bus2.wr_row !== 2'd1 || bus2.wr_col !== 2'd0) begin n_fail++; $display("FAIL ign_rc3: got %0d,%0d expected 1,0", bus2.wr_row, bus2.wr_col); end
        n_tests++; if (bus2.wr_data !== 32'h3F80_0000) begin n_fail++; $display("FAIL ign_data3: got %h expected 3f800000", bus2.wr_data); end
        tick();
        n_tests++; if (bus2.wr_row !== 2'd1 || bus2.wr_col !== 2'd1) begin n_fail++; $display("FAIL ign_rc4: got %0d,%0d expected 1,1", bus2.wr_row, bus2.wr_col); end
        n_tests++; if (bus2.wr_data !== 32'h3F80_0000) begin n_fail++; $display("FAIL ign_data4: got %h expected 3f800000", bus2.wr_data); end
        tick();
        n_tests++; if (bus2.finished !== 1'b1) begin n_fail++; $display("FAIL ign_finished: got %b expected 1", bus2.finished); end
        tick();
        n_tests++; if (bus2.busy !== 1'b0 || bus2.finished !== 1'b1) begin n_fail++; $display("FAIL ign_no_restart: got busy=%b fin=%b expected busy=0 fin=1", bus2.busy, bus2.finished); end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                n_tests++;
                if (bus2.mat_out_y[r][c] !== 32'h3F80_0000) begin
                    n_fail++; $display("FAIL ign_mat[%0d][%0d]: got %h expected 3f800000", r, c, bus2.mat_out_y[r][c]);
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        bus2.grad_in = 32'h4080_0000;
        bus2.start   = 1'b1;
        tick();
        bus2.start = 1'b0;
        tick();
        tick();
        n_tests++; if (bus2.wr_en !== 1'b1 || bus2.wr_col !== 2'd1) begin n_fail++; $display("FAIL mid_second_write: got wr_en=%b col=%0d expected 1,1", bus2.wr_en, bus2.wr_col); end
        rst = 1'b0;
        #1;
        n_tests++; if (bus2.wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_wr_en: got %b expected 0", bus2.wr_en); end
        n_tests++; if (bus2.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", bus2.busy); end
        n_tests++; if (bus2.finished !== 1'b0) begin n_fail++; $display("FAIL mid_finished: got %b expected 0", bus2.finished); end
        n_tests++; if (bus2.wr_data !== 32'h0) begin n_fail++; $display("FAIL mid_wr_data: got %h expected 00000000", bus2.wr_data); end
        n_tests++; if (bus2.mat_out_y[0][0] !== 32'h0) begin n_fail++; $display("FAIL mid_mat00: got %h expected 00000000", bus2.mat_out_y[0][0]); end
        #2;
        rst = 1'b1;
        tick();
        n_tests++; if (bus2.busy !== 1'b0 || bus2.finished !== 1'b0) begin n_fail++; $display("FAIL mid_idle: got busy=%b fin=%b expected 0,0", bus2.busy, bus2.finished); end
        bus2.grad_in = 32'hC100_0000;
        bus2.start   = 1'b1;
        tick();
        bus2.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++; if (bus2.wr_en !== 1'b1) begin n_fail++; $display("FAIL mid_re_wr_en%0d: got %b expected 1", k, bus2.wr_en); end
            n_tests++; if (bus2.wr_row !== 2'(k / 2) || bus2.wr_col !== 2'(k % 2)) begin n_fail++; $display("FAIL mid_re_rc%0d: got %0d,%0d expected %0d,%0d", k, bus2.wr_row, bus2.wr_col, k / 2, k % 2); end
            n_tests++; if (bus2.wr_data !== 32'hC000_0000) begin n_fail++; $display("FAIL mid_re_data%0d: got %h expected c0000000", k, bus2.wr_data); end
        end
        tick();
        n_tests++; if (bus2.finished !== 1'b1) begin n_fail++; $display("FAIL mid_re_finished: got %b expected 1", bus2.finished); end
    endtask

    task automatic test_default_params();
        bus13.grad_in = 32'h4329_0000;
        bus13.start   = 1'b1;
        tick();
        bus13.start = 1'b0;
        n_tests++; if (bus13.busy !== 1'b1 || bus13.wr_en !== 1'b0) begin n_fail++; $display("FAIL d13_scale: got busy=%b wr_en=%b expected 1,0", bus13.busy, bus13.wr_en); end
        for (int k = 0; k < 169; k++) begin
            tick();
            n_tests++; if (bus13.wr_en !== 1'b1) begin n_fail++; $display("FAIL d13_wr_en%0d: got %b expected 1", k, bus13.wr_en); end
            n_tests++; if (bus13.wr_row !== 5'(k / 13) || bus13.wr_col !== 5'(k % 13)) begin n_fail++; $display("FAIL d13_rc%0d: got %0d,%0d expected %0d,%0d", k, bus13.wr_row, bus13.wr_col, k / 13, k % 13); end
            n_tests++;
            if (bus13.wr_data !== 32'h3F7F_FFFF && bus13.wr_data !== 32'h3F80_0000 && bus13.wr_data !== 32'h3F80_0001) begin
                n_fail++; $display("FAIL d13_data%0d: got %h expected 3f800000 +/-1 ulp", k, bus13.wr_data);
            end
        end
        tick();
        n_tests++; if (bus13.finished !== 1'b1 || bus13.wr_en !== 1'b0) begin n_fail++; $display("FAIL d13_finished: got fin=%b wr_en=%b expected 1,0", bus13.finished, bus13.wr_en); end
        n_tests++;
        if (bus13.mat_out_y[12][12] !== 32'h3F7F_FFFF && bus13.mat_out_y[12][12] !== 32'h3F80_0000 && bus13.mat_out_y[12][12] !== 32'h3F80_0001) begin
            n_fail++; $display("FAIL d13_mat_last: got %h expected 3f800000 +/-1 ulp", bus13.mat_out_y[12][12]);
        end
        n_tests++;
        if (bus13.mat_out_y[0][0] !== 32'h3F7F_FFFF && bus13.mat_out_y[0][0] !== 32'h3F80_0000 && bus13.mat_out_y[0][0] !== 32'h3F80_0001) begin
            n_fail++; $display("FAIL d13_mat_first: got %h expected 3f800000 +/-1 ulp", bus13.mat_out_y[0][0]);
        end
    endtask

    initial begin
        rst           = 1'b0;
        bus2.start    = 1'b0;
        bus2.grad_in  = 32'h0;
        bus13.start   = 1'b0;
        bus13.grad_in = 32'h0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignored_start();
        test_reset_midrun();
        test_default_params();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
